bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 153 +++++++++++++++
 tb/tb_bus_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Two-master (instruction fetch / data) to single device-bus arbiter with IDLE/BUSY/RESP sequencing.
// Optional instruction-side starvation guard enabled by defining ARB_STARVE_GUARD_EN.
`timescale 1ns/1ps
module bus_arbiter #(
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ibus_req,
    input  logic [31:0] ibus_addr,
    output logic        ibus_ack,
    output logic [31:0] ibus_rdata,
    input  logic        dbus_req,
    input  logic        dbus_write,
    input  logic [31:0] dbus_addr,
    input  logic [3:0]  dbus_byte_enable,
    input  logic [31:0] dbus_wdata,
    output logic        dbus_ack,
    output logic [31:0] dbus_rdata,
    output logic [31:0] dev_access_addr,
    output logic [3:0]  dev_ram_byte_enable,
    output logic        dev_access_read,
    output logic        dev_access_write,
    output logic [31:0] dev_access_write_data,
    input  logic [31:0] dev_access_read_data,
    input  logic        data_bus_stall
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_r;
    logic   owner_r;
    logic   grant_dbus_s;

    if ((STARVE_LIMIT < 32'd1) || (STARVE_LIMIT > 32'd7)) begin : g_limit_check
        $error("bus_arbiter: STARVE_LIMIT must be in 1..7");
    end

`ifdef ARB_STARVE_GUARD_EN
    logic [2:0] loss_cnt_r;
    logic       starve_s;

    // Winner selection: dbus wins unless ibus has lost STARVE_LIMIT times in a row.
    always_comb begin
        starve_s     = (loss_cnt_r == 3'(STARVE_LIMIT));
        grant_dbus_s = dbus_req && !(ibus_req && starve_s);
    end

    // Consecutive ibus loss counter, updated only when a grant is made.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loss_cnt_r <= 3'd0;
        end else if ((state_r == IDLE) && (ibus_req || dbus_req)) begin
            if (!grant_dbus_s) begin
                loss_cnt_r <= 3'd0;
            end else if (ibus_req) begin
                loss_cnt_r <= loss_cnt_r + 3'd1;
            end else begin
                loss_cnt_r <= loss_cnt_r;
            end
        end else begin
            loss_cnt_r <= loss_cnt_r;
        end
    end
`else
    // Winner selection: strict dbus priority.
    always_comb begin
        grant_dbus_s = dbus_req;
    end
`endif

    // Transaction sequencer: grant in IDLE, wait out stalls in BUSY, pulse ack in RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            owner_r    <= 1'b0;
            ibus_ack   <= 1'b0;
            dbus_ack   <= 1'b0;
            ibus_rdata <= 32'd0;
            dbus_rdata <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    ibus_ack <= 1'b0;
                    dbus_ack <= 1'b0;
                    if (ibus_req || dbus_req) begin
                        owner_r <= grant_dbus_s;
                        state_r <= BUSY;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    if (!data_bus_stall) begin
                        if (owner_r) begin
                            // Writes return nothing, so keep the last read value visible.
                            if (!dbus_write) begin
                                dbus_rdata <= dev_access_read_data;
                            end else begin
                                dbus_rdata <= dbus_rdata;
                            end
                            dbus_ack <= 1'b1;
                            ibus_ack <= 1'b0;
                        end else begin
                            ibus_rdata <= dev_access_read_data;
                            ibus_ack   <= 1'b1;
                            dbus_ack   <= 1'b0;
                        end
                        state_r <= RESP;
                    end else begin
                        state_r <= BUSY;
                    end
                end
                RESP: begin
                    ibus_ack <= 1'b0;
                    dbus_ack <= 1'b0;
                    state_r  <= IDLE;
                end
                default: begin
                    ibus_ack <= 1'b0;
                    dbus_ack <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

    // Device-bus request: address/data always follow the owner, strobes only while BUSY.
    always_comb begin
        dev_access_addr       = owner_r ? dbus_addr : ibus_addr;
        dev_ram_byte_enable   = owner_r ? dbus_byte_enable : 4'b1111;
        dev_access_write_data = owner_r ? dbus_wdata : 32'd0;
        dev_access_read       = 1'b0;
        dev_access_write      = 1'b0;
        if (state_r == BUSY) begin
            if (owner_r) begin
                dev_access_read  = ~dbus_write;
                dev_access_write = dbus_write;
            end else begin
                dev_access_read  = 1'b1;
                dev_access_write = 1'b0;
            end
        end else begin
            dev_access_read  = 1'b0;
            dev_access_write = 1'b0;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter; starvation expectations follow ARB_STARVE_GUARD_EN.
`timescale 1ns/1ps
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_ack;
    logic [31:0] ibus_rdata;
    logic        dbus_req;
    logic        dbus_write;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_byte_enable;
    logic [31:0] dbus_wdata;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;
    logic [31:0] dev_access_addr;
    logic [3:0]  dev_ram_byte_enable;
    logic        dev_access_read;
    logic        dev_access_write;
    logic [31:0] dev_access_write_data;
    logic [31:0] dev_access_read_data;
    logic        data_bus_stall;

    int checks = 0;
    int errors = 0;

    bus_arbiter #(.STARVE_LIMIT(3)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .ibus_req              (ibus_req),
        .ibus_addr             (ibus_addr),
        .ibus_ack              (ibus_ack),
        .ibus_rdata            (ibus_rdata),
        .dbus_req              (dbus_req),
        .dbus_write            (dbus_write),
        .dbus_addr             (dbus_addr),
        .dbus_byte_enable      (dbus_byte_enable),
        .dbus_wdata            (dbus_wdata),
        .dbus_ack              (dbus_ack),
        .dbus_rdata            (dbus_rdata),
        .dev_access_addr       (dev_access_addr),
        .dev_ram_byte_enable   (dev_ram_byte_enable),
        .dev_access_read       (dev_access_read),
        .dev_access_write      (dev_access_write),
        .dev_access_write_data (dev_access_write_data),
        .dev_access_read_data  (dev_access_read_data),
        .data_bus_stall        (data_bus_stall)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic exp_ibus;
        rst_n                = 1'b0;
        ibus_req             = 1'b0;
        ibus_addr            = 32'h0;
        dbus_req             = 1'b0;
        dbus_write           = 1'b0;
        dbus_addr            = 32'h0;
        dbus_byte_enable     = 4'b0000;
        dbus_wdata           = 32'h0;
        dev_access_read_data = 32'h0;
        data_bus_stall       = 1'b0;

        tick();
        tick();
        chk("rst_ibus_ack", {31'd0, ibus_ack}, 32'd0);
        chk("rst_dbus_ack", {31'd0, dbus_ack}, 32'd0);
        chk("rst_ibus_rdata", ibus_rdata, 32'd0);
        chk("rst_dbus_rdata", dbus_rdata, 32'd0);
        chk("rst_rd_wr", {30'd0, dev_access_read, dev_access_write}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Single fetch, zero stall
        ibus_req             = 1'b1;
        ibus_addr            = 32'h1E000010;
        dev_access_read_data = 32'hDEADBEEF;
        tick();
        chk("f_busy_read", {31'd0, dev_access_read}, 32'd1);
        chk("f_busy_write", {31'd0, dev_access_write}, 32'd0);
        chk("f_busy_addr", dev_access_addr, 32'h1E000010);
        chk("f_busy_be", {28'd0, dev_ram_byte_enable}, 32'hF);
        chk("f_busy_wdata", dev_access_write_data, 32'd0);
        chk("f_busy_ack", {31'd0, ibus_ack}, 32'd0);
        tick();
        chk("f_resp_ack", {31'd0, ibus_ack}, 32'd1);
        chk("f_resp_rdata", ibus_rdata, 32'hDEADBEEF);
        chk("f_resp_read", {31'd0, dev_access_read}, 32'd0);
        chk("f_resp_dack", {31'd0, dbus_ack}, 32'd0);
        ibus_req = 1'b0;
        tick();
        chk("f_ack_drop", {31'd0, ibus_ack}, 32'd0);

        // Data read to seed dbus_rdata
        dbus_req             = 1'b1;
        dbus_write           = 1'b0;
        dbus_addr            = 32'h00000100;
        dbus_byte_enable     = 4'b1111;
        dev_access_read_data = 32'hCAFEF00D;
        tick();
        chk("dr_read", {31'd0, dev_access_read}, 32'd1);
        chk("dr_write", {31'd0, dev_access_write}, 32'd0);
        chk("dr_addr", dev_access_addr, 32'h00000100);
        tick();
        chk("dr_ack", {31'd0, dbus_ack}, 32'd1);
        chk("dr_iack", {31'd0, ibus_ack}, 32'd0);
        chk("dr_rdata", dbus_rdata, 32'hCAFEF00D);
        dbus_req = 1'b0;
        tick();

        // Stalled write: 5 stall cycles -> 6 BUSY cycles
        dbus_req             = 1'b1;
        dbus_write           = 1'b1;
        dbus_addr            = 32'h1FD003F8;
        dbus_byte_enable     = 4'b0001;
        dbus_wdata           = 32'h41;
        dev_access_read_data = 32'h12345678;
        data_bus_stall       = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("dw_write_%0d", i), {31'd0, dev_access_write}, 32'd1);
            chk($sformatf("dw_read_%0d", i), {31'd0, dev_access_read}, 32'd0);
            chk($sformatf("dw_ack_%0d", i), {31'd0, dbus_ack}, 32'd0);
            if (i == 0) begin
                chk("dw_addr", dev_access_addr, 32'h1FD003F8);
                chk("dw_be", {28'd0, dev_ram_byte_enable}, 32'h1);
                chk("dw_wdata", dev_access_write_data, 32'h41);
            end
            if (i == 5) data_bus_stall = 1'b0;
            tick();
        end
        chk("dw_resp_ack", {31'd0, dbus_ack}, 32'd1);
        chk("dw_resp_write", {31'd0, dev_access_write}, 32'd0);
        chk("dw_rdata_kept", dbus_rdata, 32'hCAFEF00D);
        dbus_req   = 1'b0;
        dbus_write = 1'b0;
        tick();
        chk("dw_ack_drop", {31'd0, dbus_ack}, 32'd0);

        // Simultaneous requests: dbus first, then ibus
        ibus_req             = 1'b1;
        ibus_addr            = 32'h1E000020;
        dbus_req             = 1'b1;
        dbus_addr            = 32'h00000200;
        dbus_byte_enable     = 4'b1111;
        dev_access_read_data = 32'h11111111;
        tick();
        chk("bo_first_addr", dev_access_addr, 32'h00000200);
        chk("bo_first_read", {31'd0, dev_access_read}, 32'd1);
        tick();
        chk("bo_first_acks", {30'd0, ibus_ack, dbus_ack}, 32'd1);
        chk("bo_first_rdata", dbus_rdata, 32'h11111111);
        dbus_req             = 1'b0;
        dev_access_read_data = 32'h22222222;
        tick();
        chk("bo_idle_acks", {30'd0, ibus_ack, dbus_ack}, 32'd0);
        chk("bo_idle_read", {31'd0, dev_access_read}, 32'd0);
        tick();
        chk("bo_second_addr", dev_access_addr, 32'h1E000020);
        chk("bo_second_read", {31'd0, dev_access_read}, 32'd1);
        tick();
        chk("bo_second_acks", {30'd0, ibus_ack, dbus_ack}, 32'd2);
        chk("bo_second_rdata", ibus_rdata, 32'h22222222);
        ibus_req = 1'b0;
        tick();

        // Reset in the middle of a stalled write
        dbus_req       = 1'b1;
        dbus_write     = 1'b1;
        dbus_addr      = 32'h00000300;
        data_bus_stall = 1'b1;
        tick();
        chk("rb_write_before", {31'd0, dev_access_write}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rb_strobes_async", {30'd0, dev_access_read, dev_access_write}, 32'd0);
        chk("rb_acks_async", {30'd0, ibus_ack, dbus_ack}, 32'd0);
        chk("rb_dbus_rdata", dbus_rdata, 32'd0);
        dbus_req       = 1'b0;
        dbus_write     = 1'b0;
        data_bus_stall = 1'b0;
        tick();
        tick();
        chk("rb_acks_held", {30'd0, ibus_ack, dbus_ack}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rb_idle_after", {30'd0, dev_access_read, dev_access_write}, 32'd0);
        chk("rb_no_ack", {30'd0, ibus_ack, dbus_ack}, 32'd0);
        ibus_req             = 1'b1;
        ibus_addr            = 32'h1E000040;
        dev_access_read_data = 32'hA5A5A5A5;
        tick();
        chk("rb_new_read", {31'd0, dev_access_read}, 32'd1);
        chk("rb_new_addr", dev_access_addr, 32'h1E000040);
        tick();
        chk("rb_new_acks", {30'd0, ibus_ack, dbus_ack}, 32'd2);
        chk("rb_new_rdata", ibus_rdata, 32'hA5A5A5A5);
        ibus_req = 1'b0;
        tick();

        // Continuous contention: starvation guard decides the 4th grant
        ibus_req             = 1'b1;
        ibus_addr            = 32'h1E000080;
        dbus_req             = 1'b1;
        dbus_write           = 1'b0;
        dbus_addr            = 32'h00000400;
        dev_access_read_data = 32'h5A5A5A5A;
        for (int k = 1; k <= 5; k++) begin
`ifdef ARB_STARVE_GUARD_EN
            exp_ibus = (k == 4);
`else
            exp_ibus = 1'b0;
`endif
            tick();
            chk($sformatf("sv_grant_%0d", k), dev_access_addr, exp_ibus ? 32'h1E000080 : 32'h00000400);
            tick();
            chk($sformatf("sv_acks_%0d", k), {30'd0, ibus_ack, dbus_ack}, exp_ibus ? 32'd2 : 32'd1);
            tick();
        end
        ibus_req = 1'b0;
        dbus_req = 1'b0;
        tick();
        chk("sv_idle_acks", {30'd0, ibus_ack, dbus_ack}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Mutual exclusion of the two acks, sampled every cycle
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checks++;
            assert (!(ibus_ack === 1'b1 && dbus_ack === 1'b1)) else begin
                errors++;
                $error("FAIL ack_overlap observed=%b%b expected=not 11", ibus_ack, dbus_ack);
            end
        end
    end

endmodule
